// File: rtl/mem_req_sequencer.sv
// Request sequencer: buffers host requests in a FIFO and issues one memory access at a
// time as a single-cycle read/write strobe, returning exactly one response per access.
module mem_req_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int QUIET_CYC = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int QC_W    = (QUIET_CYC > 1) ? $clog2(QUIET_CYC + 1) : 1;
  localparam int TM_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [QC_W-1:0]  QUIET_LAST = QC_W'(QUIET_CYC - 1);
  localparam logic [QC_W-1:0]  QC_ONE     = QC_W'(1);
  localparam logic [QC_W-1:0]  QC_ZERO    = QC_W'(0);
  localparam logic [TM_W-1:0]  TIMER_LAST = TM_W'(TIMEOUT - 1);
  localparam logic [TM_W-1:0]  TM_ONE     = TM_W'(1);
  localparam logic [TM_W-1:0]  TM_ZERO    = TM_W'(0);

  typedef enum logic [1:0] {
    ST_QUIET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [QC_W-1:0]     quiet_cnt_r, quiet_cnt_nxt_s;
  logic [TM_W-1:0]     timer_r, timer_nxt_s;
  logic                cur_wr_r, cur_wr_nxt_s;
  logic                read_r, read_nxt_s;
  logic                write_r, write_nxt_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_nxt_s;
  logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_nxt_s;
  logic                rsp_valid_r, rsp_valid_nxt_s;
  logic [DATA_W-1:0]   rsp_data_r, rsp_data_nxt_s;
  logic                rsp_err_r, rsp_err_nxt_s;
  logic                req_ready_r, req_ready_nxt_s;

  logic [ENTRY_W-1:0]  fifo_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    count_r, count_nxt_s;
  logic                push_s, pop_s;
  logic [ENTRY_W-1:0]  head_s;

  // ready is registered from the post-edge count, so a pop cannot open a full FIFO early
  assign push_s = req_valid && req_ready_r;
  assign head_s = fifo_r[rd_ptr_r];

  // next FIFO occupancy from this cycle's push/pop
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_r[i] <= {ENTRY_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= {req_wr, req_addr, req_wdata};
        wr_ptr_r         <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // sequencing FSM: next state and next registered outputs
  always_comb begin
    state_nxt_s     = state_r;
    quiet_cnt_nxt_s = quiet_cnt_r;
    timer_nxt_s     = timer_r;
    cur_wr_nxt_s    = cur_wr_r;
    read_nxt_s      = 1'b0;
    write_nxt_s     = 1'b0;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    rsp_valid_nxt_s = 1'b0;
    rsp_data_nxt_s  = {DATA_W{1'b0}};
    rsp_err_nxt_s   = 1'b0;
    pop_s           = 1'b0;
    case (state_r)
      ST_QUIET: begin
        if (quiet_cnt_r == QUIET_LAST) begin
          state_nxt_s     = ST_IDLE;
          quiet_cnt_nxt_s = QC_ZERO;
        end else begin
          quiet_cnt_nxt_s = quiet_cnt_r + QC_ONE;
        end
      end
      ST_IDLE: begin
        if (count_r != CNT_ZERO) begin
          pop_s           = 1'b1;
          cur_wr_nxt_s    = head_s[ENTRY_W-1];
          mem_addr_nxt_s  = head_s[DATA_W +: ADDR_W];
          mem_wdata_nxt_s = head_s[DATA_W-1:0];
          read_nxt_s      = !head_s[ENTRY_W-1];
          write_nxt_s     = head_s[ENTRY_W-1];
          state_nxt_s     = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        // an ack during the strobe cycle completes the access just like one in WAIT
        if (mem_ack) begin
          rsp_valid_nxt_s = 1'b1;
          rsp_data_nxt_s  = cur_wr_r ? {DATA_W{1'b0}} : mem_rdata;
          state_nxt_s     = ST_IDLE;
          timer_nxt_s     = TM_ZERO;
        end else if (state_r == ST_ISSUE) begin
          state_nxt_s = ST_WAIT;
          timer_nxt_s = TM_ZERO;
        end else if (timer_r == TIMER_LAST) begin
          rsp_valid_nxt_s = 1'b1;
          rsp_err_nxt_s   = 1'b1;
          state_nxt_s     = ST_IDLE;
          timer_nxt_s     = TM_ZERO;
        end else begin
          timer_nxt_s = timer_r + TM_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_QUIET;
      end
    endcase
    req_ready_nxt_s = (state_nxt_s != ST_QUIET) && (count_nxt_s != FULL_CNT);
  end

  // FSM state and output registers; reset clears strobes and responses immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_QUIET;
      quiet_cnt_r <= QC_ZERO;
      timer_r     <= TM_ZERO;
      cur_wr_r    <= 1'b0;
      read_r      <= 1'b0;
      write_r     <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
      req_ready_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      quiet_cnt_r <= quiet_cnt_nxt_s;
      timer_r     <= timer_nxt_s;
      cur_wr_r    <= cur_wr_nxt_s;
      read_r      <= read_nxt_s;
      write_r     <= write_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_data_r  <= rsp_data_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      req_ready_r <= req_ready_nxt_s;
    end
  end

  assign read      = read_r;
  assign write     = write_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign req_ready = req_ready_r;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer: directed scenarios plus randomized traffic, all checked
// against a transaction-level reference model (request queue + outstanding-access tracker).
module tb_mem_req_sequencer;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 4;
  localparam int QUIET_CYC = 2;
  localparam int TIMEOUT   = 15;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  mem_req_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .QUIET_CYC(QUIET_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .read(read), .write(write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobes are never active in reset and never overlap
  assert property (@(posedge clk) !reset |-> (!read && !write))
    else $error("FAIL strobe_in_reset");
  assert property (@(posedge clk) !(read && write))
    else $error("FAIL read_and_write");

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // reference model state
  req_t              q[$];
  req_t              cur;
  int                m_quiet;
  bit                m_busy;
  int                m_k;
  bit                exp_ready, exp_rd, exp_wr, exp_rsp, exp_err;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata, exp_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  int n_rsp  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // advance the model by one rising edge using the inputs present at that edge
  task automatic model_edge();
    bit push;
    exp_rd = 1'b0; exp_wr = 1'b0; exp_rsp = 1'b0; exp_err = 1'b0; exp_rdata = 8'h00;
    if (!reset) begin
      q.delete();
      m_busy = 1'b0; m_quiet = 0; m_k = 0; exp_ready = 1'b0;
    end else begin
      push = req_valid && exp_ready;
      if (m_busy) begin
        m_k++;
        if (mem_ack) begin
          exp_rsp = 1'b1; exp_rdata = cur.wr ? 8'h00 : mem_rdata; m_busy = 1'b0;
        end else if (m_k == TIMEOUT + 1) begin
          exp_rsp = 1'b1; exp_err = 1'b1; m_busy = 1'b0;
        end
      end else if (m_quiet >= QUIET_CYC && q.size() > 0) begin
        cur = q.pop_front();
        m_busy = 1'b1; m_k = 0;
        exp_rd = !cur.wr; exp_wr = cur.wr; exp_addr = cur.addr; exp_wdata = cur.wdata;
      end
      if (m_quiet < QUIET_CYC) m_quiet++;
      if (push) q.push_back({req_wr, req_addr, req_wdata});
      exp_ready = (m_quiet >= QUIET_CYC) && (q.size() < DEPTH);
    end
  endtask

  task automatic compare_all();
    chk("read", 32'(read), 32'(exp_rd));
    chk("write", 32'(write), 32'(exp_wr));
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rd || exp_wr) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (exp_wr) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    if (exp_rsp) begin
      chk("rsp_data", 32'(rsp_data), 32'(exp_rdata));
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    end
    if (rsp_valid) n_rsp++;
  endtask

  // one clock: edge, model update, sample 1ns later, return at the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    int i, guard, base, rst_hold;
    bit acc;
    reset = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    m_quiet = 0; m_busy = 1'b0; m_k = 0; exp_ready = 1'b0;

    // 1) reset held with req_valid high, then the quiet window
    for (int c = 0; c < 3; c++) begin
      req_addr = 8'(c + 1);
      step();
      chk("t1_ready_in_reset", 32'(req_ready), 32'd0);
    end
    reset = 1'b1; req_valid = 1'b0;
    step();
    chk("t1_ready_quiet", 32'(req_ready), 32'd0);
    step();
    chk("t1_ready_after_quiet", 32'(req_ready), 32'd1);

    // 2) single read, ack two clocks after the strobe
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h12; req_wdata = 8'h00;
    step();
    req_valid = 1'b0;
    step();
    chk("t2_read_strobe", 32'(read), 32'd1);
    chk("t2_mem_addr", 32'(mem_addr), 32'h12);
    step();
    chk("t2_read_pulse_end", 32'(read), 32'd0);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    step();
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_rsp_data", 32'(rsp_data), 32'hA5);
    chk("t2_rsp_err", 32'(rsp_err), 32'd0);
    mem_ack = 1'b0;
    step();

    // 3) five writes with no ack: FIFO fills, every access times out in order
    base = n_rsp; i = 0; guard = 0;
    while (i < 5 && guard < 50) begin
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'(8'h30 + i); req_wdata = 8'(8'h60 + i);
      acc = exp_ready;
      step();
      if (acc) i++;
      guard++;
    end
    req_valid = 1'b0;
    chk("t3_pushed", 32'(i), 32'd5);
    chk("t3_full_ready", 32'(req_ready), 32'd0);
    for (int w = 0; w < 200 && (n_rsp - base) < 5; w++) step();
    chk("t3_rsp_count", 32'(n_rsp - base), 32'd5);

    // 4) reset dropped while a write strobe is high
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h40; req_wdata = 8'hC0;
    step();
    req_addr = 8'h41; req_wdata = 8'hC1;
    step();
    chk("t4_write_before", 32'(write), 32'd1);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    chk("t4_write_drop", 32'(write), 32'd0);
    chk("t4_rsp_drop", 32'(rsp_valid), 32'd0);
    chk("t4_ready_drop", 32'(req_ready), 32'd0);
    base = n_rsp;
    step();
    step();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) step();
    chk("t4_no_stale_rsp", 32'(n_rsp - base), 32'd0);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h77;
    step();
    req_valid = 1'b0;
    step();
    chk("t4_read_after_quiet", 32'(read), 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    step();
    chk("t4_rsp_after_quiet", 32'(rsp_data), 32'h3C);
    mem_ack = 1'b0;
    step();

    // 5) ack while idle with an empty FIFO is ignored
    mem_ack = 1'b1; mem_rdata = 8'h99;
    step();
    chk("t5_ack_idle", 32'(rsp_valid), 32'd0);
    mem_ack = 1'b0;
    step();

    // 6) randomized requests, acks and resets
    rst_hold = 0;
    for (int c = 0; c < 1000; c++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 1'b1;
      end else if ($urandom_range(99) == 0) begin
        reset = 1'b0;
        rst_hold = $urandom_range(3, 1);
        #1;
        chk("async_clear_strobe", 32'(read | write), 32'd0);
        chk("async_clear_rsp", 32'(rsp_valid), 32'd0);
      end
      req_valid = 1'($urandom_range(1));
      req_wr    = 1'($urandom_range(1));
      req_addr  = 8'($urandom_range(255));
      req_wdata = 8'($urandom_range(255));
      mem_ack   = m_busy ? ($urandom_range(5) == 0) : ($urandom_range(9) == 0);
      mem_rdata = 8'($urandom_range(255));
      step();
    end
    reset = 1'b1; req_valid = 1'b0; mem_ack = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
